// File: rtl/probe_cond_pkg.sv
// Shared definitions for the probe input conditioner bank.
//   EDGE_BOTH/EDGE_RISE/EDGE_FALL : encodings selecting which debounced edges are counted
//   cnt_step()                    : one counter increment with saturate-or-wrap and overflow flag
package probe_cond_pkg;

  localparam int EDGE_BOTH = 0;
  localparam int EDGE_RISE = 1;
  localparam int EDGE_FALL = 2;

  // Returns {overflow, next_value}. The counter is 'width' bits (1..32), held
  // in the low bits of a 32-bit carrier. At all-ones the result either holds
  // all-ones or wraps to zero, and the overflow bit is raised in both cases.
  function automatic logic [32:0] cnt_step(input logic [31:0] val,
                                           input int unsigned width,
                                           input logic saturate);
    logic [31:0] top;
    logic [32:0] res;
    top = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    if (val == top) res = {1'b1, (saturate ? top : 32'd0)};
    else            res = {1'b0, val + 32'd1};
    return res;
  endfunction

endpackage

// File: rtl/probe_cond_chan.sv
// One probe channel: synchroniser, runtime-programmable debounce, debounced
// edge pulses, edge counter with sticky overflow, and snapshot clear.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   cg              clock-enable; low freezes state and blanks the pulses
//   dcycles         required stable cycles (0 behaves as 1)
//   raw             asynchronous probe input
//   snap_clr        clear counter and overflow on this enabled edge
//   level           debounced level
//   rise, fall      one-cycle pulses on debounced edges
//   count           live edge counter
//   count_nxt       counter value after any increment due this cycle
//   ovf_nxt         overflow flag including any overflow due this cycle
module probe_cond_chan
  import probe_cond_pkg::*;
#(
  parameter int N_SYNC     = 2,
  parameter int DEBOUNCE_W = 18,
  parameter int EDGECNTR_W = 8,
  parameter int EDGE_MODE  = 0,
  parameter int SATURATE   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cg,
  input  logic [DEBOUNCE_W-1:0] dcycles,
  input  logic                  raw,
  input  logic                  snap_clr,
  output logic                  level,
  output logic                  rise,
  output logic                  fall,
  output logic [EDGECNTR_W-1:0] count,
  output logic [EDGECNTR_W-1:0] count_nxt,
  output logic                  ovf_nxt
);

  logic [N_SYNC-1:0]     sync_p0;
  logic [DEBOUNCE_W-1:0] db_cnt_p0;
  logic                  lvl_p0;
  logic                  rise_p0;
  logic                  fall_p0;
  logic                  vld_p1;
  logic [EDGECNTR_W-1:0] count_p1;
  logic                  ovf_p1;

  logic                  s;
  logic [DEBOUNCE_W-1:0] d_m1;
  logic                  upd;
  logic                  cnt_edge;
  logic [32:0]           step;

  assign s = sync_p0[N_SYNC-1];

  always_comb begin
    d_m1     = (dcycles == '0) ? '0 : dcycles - DEBOUNCE_W'(1);
    upd      = (s != lvl_p0) && (db_cnt_p0 >= d_m1);
    cnt_edge = upd;
    if (EDGE_MODE == EDGE_RISE)      cnt_edge = upd && s;
    else if (EDGE_MODE == EDGE_FALL) cnt_edge = upd && !s;
  end

  // Counter stage: the increment flagged last cycle is applied here, so the
  // snapshot path can capture it in the same edge that clears the counter.
  always_comb begin
    step      = cnt_step(32'(count_p1), EDGECNTR_W, (SATURATE != 0));
    count_nxt = count_p1;
    ovf_nxt   = ovf_p1;
    if (vld_p1) begin
      count_nxt = step[EDGECNTR_W-1:0];
      ovf_nxt   = ovf_p1 | step[32];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0   <= '0;
      db_cnt_p0 <= '0;
      lvl_p0    <= 1'b0;
      rise_p0   <= 1'b0;
      fall_p0   <= 1'b0;
      vld_p1    <= 1'b0;
      count_p1  <= '0;
      ovf_p1    <= 1'b0;
    end else if (cg) begin
      // Stage p0: synchronise and debounce
      sync_p0 <= {sync_p0[N_SYNC-2:0], raw};
      if (s == lvl_p0) begin
        db_cnt_p0 <= '0;
      end else if (upd) begin
        db_cnt_p0 <= '0;
        lvl_p0    <= s;
      end else if (db_cnt_p0 != '1) begin
        db_cnt_p0 <= db_cnt_p0 + DEBOUNCE_W'(1);
      end
      rise_p0 <= upd & s;
      fall_p0 <= upd & ~s;
      vld_p1  <= cnt_edge;
      // Stage p1: count, or hand the total to the snapshot and restart
      if (snap_clr) begin
        count_p1 <= '0;
        ovf_p1   <= 1'b0;
      end else begin
        count_p1 <= count_nxt;
        ovf_p1   <= ovf_nxt;
      end
    end else begin
      // Frozen: pulses are dropped, but a pending count increment is kept.
      rise_p0 <= 1'b0;
      fall_p0 <= 1'b0;
    end
  end

  assign level = lvl_p0;
  assign rise  = rise_p0 & cg;
  assign fall  = fall_p0 & cg;
  assign count = count_p1;

endmodule

// File: rtl/probe_cond_bank.sv
// N-channel probe input conditioner: per-channel sync + debounce + edge
// pulses + edge counters, with a shared atomic snapshot-and-clear.
// Ports:
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   i_cg               clock-enable; low freezes all state
//   i_debounceCycles   required stable cycles (0 behaves as 1)
//   i_bits             raw probe inputs
//   i_snap             snapshot request (ignored while i_cg is low)
//   o_bits             debounced levels
//   o_rise, o_fall     one-cycle debounced edge pulses
//   o_count            live counters, channel k at [k*EDGECNTR_W +: EDGECNTR_W]
//   o_snapCount        counters captured by the last snapshot
//   o_snapOvf          per-channel overflow within the captured window
//   o_snapValid        one-cycle pulse when snapshot outputs update
module probe_cond_bank
  import probe_cond_pkg::*;
#(
  parameter int N_CH       = 8,
  parameter int N_SYNC     = 2,
  parameter int DEBOUNCE_W = 18,
  parameter int EDGECNTR_W = 8,
  parameter int EDGE_MODE  = 0,
  parameter int SATURATE   = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_cg,
  input  logic [DEBOUNCE_W-1:0]      i_debounceCycles,
  input  logic [N_CH-1:0]            i_bits,
  input  logic                       i_snap,
  output logic [N_CH-1:0]            o_bits,
  output logic [N_CH-1:0]            o_rise,
  output logic [N_CH-1:0]            o_fall,
  output logic [N_CH*EDGECNTR_W-1:0] o_count,
  output logic [N_CH*EDGECNTR_W-1:0] o_snapCount,
  output logic [N_CH-1:0]            o_snapOvf,
  output logic                       o_snapValid
);

  logic                       snap_req;
  logic [N_CH*EDGECNTR_W-1:0] count_nxt;
  logic [N_CH-1:0]            ovf_nxt;
  logic [N_CH*EDGECNTR_W-1:0] snap_count_p2;
  logic [N_CH-1:0]            snap_ovf_p2;
  logic                       snap_vld_p2;

  assign snap_req = i_snap & i_cg;

  for (genvar k = 0; k < N_CH; k++) begin : g_chan
    probe_cond_chan #(
      .N_SYNC    (N_SYNC),
      .DEBOUNCE_W(DEBOUNCE_W),
      .EDGECNTR_W(EDGECNTR_W),
      .EDGE_MODE (EDGE_MODE),
      .SATURATE  (SATURATE)
    ) u_chan (
      .clk      (i_clk),
      .rst_n    (i_rst_n),
      .cg       (i_cg),
      .dcycles  (i_debounceCycles),
      .raw      (i_bits[k]),
      .snap_clr (snap_req),
      .level    (o_bits[k]),
      .rise     (o_rise[k]),
      .fall     (o_fall[k]),
      .count    (o_count[k*EDGECNTR_W +: EDGECNTR_W]),
      .count_nxt(count_nxt[k*EDGECNTR_W +: EDGECNTR_W]),
      .ovf_nxt  (ovf_nxt[k])
    );
  end

  // Stage p2: snapshot capture, same edge as the live counters clear
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      snap_count_p2 <= '0;
      snap_ovf_p2   <= '0;
      snap_vld_p2   <= 1'b0;
    end else if (i_cg) begin
      snap_vld_p2 <= i_snap;
      if (i_snap) begin
        snap_count_p2 <= count_nxt;
        snap_ovf_p2   <= ovf_nxt;
      end
    end else begin
      snap_vld_p2 <= 1'b0;
    end
  end

  assign o_snapCount = snap_count_p2;
  assign o_snapOvf   = snap_ovf_p2;
  assign o_snapValid = snap_vld_p2 & i_cg;

endmodule

// File: tb/tb_probe_cond_bank.sv
// Directed bench for probe_cond_bank. Three instances share one stimulus:
//   b: both edges, saturating, 8-bit counters
//   s: rise only, saturating, 4-bit counters
//   w: fall only, wrapping, 4-bit counters
module tb_probe_cond_bank;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        cg    = 1'b1;
  logic        snap  = 1'b0;
  logic [17:0] dcyc  = 18'd4;
  logic [7:0]  bits  = 8'h00;

  always #5 clk = ~clk;

  logic [7:0]  bits_b, rise_b, fall_b, sovf_b;
  logic [63:0] cnt_b, scnt_b;
  logic        sv_b;
  logic [7:0]  bits_s, rise_s, fall_s, sovf_s;
  logic [31:0] cnt_s, scnt_s;
  logic        sv_s;
  logic [7:0]  bits_w, rise_w, fall_w, sovf_w;
  logic [31:0] cnt_w, scnt_w;
  logic        sv_w;

  probe_cond_bank #(.N_CH(8), .N_SYNC(2), .DEBOUNCE_W(18), .EDGECNTR_W(8),
                    .EDGE_MODE(0), .SATURATE(1)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_cg(cg), .i_debounceCycles(dcyc),
    .i_bits(bits), .i_snap(snap), .o_bits(bits_b), .o_rise(rise_b),
    .o_fall(fall_b), .o_count(cnt_b), .o_snapCount(scnt_b),
    .o_snapOvf(sovf_b), .o_snapValid(sv_b));

  probe_cond_bank #(.N_CH(8), .N_SYNC(2), .DEBOUNCE_W(18), .EDGECNTR_W(4),
                    .EDGE_MODE(1), .SATURATE(1)) dut_s (
    .i_clk(clk), .i_rst_n(rst_n), .i_cg(cg), .i_debounceCycles(dcyc),
    .i_bits(bits), .i_snap(snap), .o_bits(bits_s), .o_rise(rise_s),
    .o_fall(fall_s), .o_count(cnt_s), .o_snapCount(scnt_s),
    .o_snapOvf(sovf_s), .o_snapValid(sv_s));

  probe_cond_bank #(.N_CH(8), .N_SYNC(2), .DEBOUNCE_W(18), .EDGECNTR_W(4),
                    .EDGE_MODE(2), .SATURATE(0)) dut_w (
    .i_clk(clk), .i_rst_n(rst_n), .i_cg(cg), .i_debounceCycles(dcyc),
    .i_bits(bits), .i_snap(snap), .o_bits(bits_w), .o_rise(rise_w),
    .o_fall(fall_w), .o_count(cnt_w), .o_snapCount(scnt_w),
    .o_snapOvf(sovf_w), .o_snapValid(sv_w));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [7:0] c8(input logic [63:0] v, input int k);
    return v[k*8 +: 8];
  endfunction

  function automatic logic [3:0] c4(input logic [31:0] v, input int k);
    return v[k*4 +: 4];
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen, first, sum, bad_lvl, bad_pulse, bad_sv, bad_cnt;
    logic [7:0]  save_bits;
    logic [63:0] save_cnt, save_scnt;

    // Reset state
    tick(2);
    check_eq("rst_bits", bits_b, 0);
    check_eq("rst_count", cnt_b, 0);
    check_eq("rst_snapcount", scnt_b, 0);
    check_eq("rst_snapvalid", sv_b, 0);
    rst_n = 1'b1;
    tick(1);

    // Latency: N_SYNC + D = 6 cycles to o_bits, count one cycle later
    bits[3] = 1'b1;
    tick(5);
    check_eq("lat_early", bits_b[3], 0);
    tick(1);
    check_eq("lat_bits", bits_b[3], 1);
    check_eq("lat_rise", rise_b, 8'h08);
    check_eq("lat_fall_quiet", fall_b, 0);
    check_eq("lat_cnt_not_yet", c8(cnt_b, 3), 0);
    tick(1);
    check_eq("lat_rise_one_cycle", rise_b, 0);
    check_eq("lat_cnt_b", c8(cnt_b, 3), 1);
    check_eq("lat_cnt_s", c4(cnt_s, 3), 1);
    check_eq("lat_cnt_w", c4(cnt_w, 3), 0);
    bits[3] = 1'b0;
    tick(6);
    check_eq("fall_pulse", fall_b, 8'h08);
    check_eq("fall_bits", bits_b[3], 0);
    tick(1);
    check_eq("fall_cnt_b", c8(cnt_b, 3), 2);
    check_eq("fall_cnt_w", c4(cnt_w, 3), 1);

    // Glitch of 3 cycles rejected, 4 cycles accepted
    bits[0] = 1'b1;
    tick(3);
    bits[0] = 1'b0;
    seen = 0;
    repeat (12) begin
      tick(1);
      if (bits_b[0] || rise_b[0]) seen++;
    end
    check_eq("glitch_seen", seen, 0);
    check_eq("glitch_cnt", c8(cnt_b, 0), 0);
    bits[0] = 1'b1;
    first = 0;
    for (int i = 1; i <= 14; i++) begin
      tick(1);
      if (i == 4) bits[0] = 1'b0;
      if (rise_b[0] && first == 0) first = i;
    end
    check_eq("pulse4_rise_at", first, 6);
    check_eq("pulse4_bits_after", bits_b[0], 0);
    check_eq("pulse4_cnt", c8(cnt_b, 0), 2);

    // 20 clean pulses on channel 1
    repeat (20) begin
      bits[1] = 1'b1;
      tick(6);
      bits[1] = 1'b0;
      tick(6);
    end
    tick(4);
    check_eq("sat_live_s", c4(cnt_s, 1), 15);
    check_eq("wrap_live_w", c4(cnt_w, 1), 4);
    check_eq("both_live_b", c8(cnt_b, 1), 40);
    snap = 1'b1;
    tick(1);
    snap = 1'b0;
    check_eq("snap1_valid", sv_b, 1);
    check_eq("snap1_cnt_s", c4(scnt_s, 1), 15);
    check_eq("snap1_ovf_s", sovf_s, 8'h02);
    check_eq("snap1_live_s", c4(cnt_s, 1), 0);
    check_eq("snap1_cnt_w", c4(scnt_w, 1), 4);
    check_eq("snap1_ovf_w1", sovf_w[1], 1);
    check_eq("snap1_cnt_b1", c8(scnt_b, 1), 40);
    check_eq("snap1_cnt_b3", c8(scnt_b, 3), 2);
    check_eq("snap1_ovf_b", sovf_b, 0);
    tick(1);
    check_eq("snap1_valid_one_cycle", sv_b, 0);

    // 17 pulses: wrapping fall counter ends at 1 with overflow
    repeat (17) begin
      bits[1] = 1'b1;
      tick(6);
      bits[1] = 1'b0;
      tick(6);
    end
    tick(4);
    snap = 1'b1;
    tick(1);
    snap = 1'b0;
    check_eq("snap2_cnt_w", c4(scnt_w, 1), 1);
    check_eq("snap2_ovf_w", sovf_w, 8'h02);
    check_eq("snap2_cnt_s", c4(scnt_s, 1), 15);
    check_eq("snap2_ovf_s1", sovf_s[1], 1);
    check_eq("snap2_cnt_b", c8(scnt_b, 1), 34);
    check_eq("snap2_ovf_b", sovf_b, 0);

    // Snapshot on the very edge the count increments
    bits[2] = 1'b1;
    tick(6);
    check_eq("coinc_rise", rise_b[2], 1);
    snap = 1'b1;
    tick(1);
    snap = 1'b0;
    check_eq("coinc_valid", sv_b, 1);
    check_eq("coinc_snap_b", c8(scnt_b, 2), 1);
    check_eq("coinc_live_b", c8(cnt_b, 2), 0);
    check_eq("coinc_snap_s", c4(scnt_s, 2), 1);
    tick(3);
    check_eq("coinc_live_stays", c8(cnt_b, 2), 0);

    // 10 edges against a free-running snapshot cadence
    sum = 0;
    for (int i = 0; i < 80; i++) begin
      snap = (i % 3 == 0);
      if ((i % 7 == 0) && (i < 70)) bits[2] = ~bits[2];
      tick(1);
      if (sv_b) sum += int'(c8(scnt_b, 2));
    end
    snap = 1'b0;
    check_eq("snap_sum_10", sum, 10);

    // Runtime change of the debounce length, and 0 treated as 1
    dcyc = 18'd20;
    bits[6] = 1'b1;
    tick(8);
    check_eq("dchg_hold", bits_b[6], 0);
    dcyc = 18'd2;
    tick(1);
    check_eq("dchg_immediate", bits_b[6], 1);
    dcyc = 18'd0;
    bits[6] = 1'b0;
    tick(2);
    check_eq("d0_early", bits_b[6], 1);
    tick(1);
    check_eq("d0_bits", bits_b[6], 0);
    check_eq("d0_fall", fall_b[6], 1);
    dcyc = 18'd4;
    tick(3);

    // Clock-enable low with a mismatch mid-count
    bits[5] = 1'b1;
    tick(3);
    save_bits = bits_b;
    save_cnt  = cnt_b;
    save_scnt = scnt_b;
    cg = 1'b0;
    bad_lvl = 0; bad_pulse = 0; bad_sv = 0; bad_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      bits = 8'($urandom);
      snap = (i % 5 == 0);
      tick(1);
      if (bits_b !== save_bits) bad_lvl++;
      if ((rise_b | fall_b) != 0) bad_pulse++;
      if (sv_b) bad_sv++;
      if ((cnt_b !== save_cnt) || (scnt_b !== save_scnt)) bad_cnt++;
    end
    check_eq("cg_levels", bad_lvl, 0);
    check_eq("cg_pulses", bad_pulse, 0);
    check_eq("cg_snapvalid", bad_sv, 0);
    check_eq("cg_counters", bad_cnt, 0);
    bits = 8'h24;
    snap = 1'b0;
    cg = 1'b1;
    tick(1);
    check_eq("cg_snap_not_queued", sv_b, 0);
    tick(1);
    check_eq("cg_resume_early", bits_b[5], 0);
    tick(1);
    check_eq("cg_resume_bits", bits_b[5], 1);
    check_eq("cg_resume_rise", rise_b, 8'h20);

    // Asynchronous reset in the middle of a debounce count
    bits[5] = 1'b0;
    tick(3);
    rst_n = 1'b0;
    #1;
    check_eq("arst_bits", bits_b, 0);
    check_eq("arst_count", cnt_b, 0);
    check_eq("arst_snapcount", scnt_b, 0);
    check_eq("arst_snapovf", sovf_b, 0);
    bits = 8'h24;
    tick(2);
    rst_n = 1'b1;
    tick(5);
    check_eq("post_rst_early", bits_b, 0);
    tick(1);
    check_eq("post_rst_bits", bits_b, 8'h24);
    check_eq("post_rst_rise", rise_b, 8'h24);
    tick(1);
    check_eq("post_rst_cnt5", c8(cnt_b, 5), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/probe_cond_bank.md
Name: probe_cond_bank

Overview:
- Parametrised N-channel probe input conditioner: per-channel synchroniser, runtime-programmable debounce, debounced edge pulses and per-channel edge counters.
- Counters support atomic snapshot-and-clear.
- Sits between raw probe pins and correlator engines or host readout.
- Generalises the single-bit sync/debounce used for board pushbuttons to a wide probe bus with counting and snapshot.

Parameters:
N_CH, 8, number of probe channels (>=1).
N_SYNC, 2, synchroniser flops per channel (>=2).
DEBOUNCE_W, 18, width of debounce count and i_debounceCycles.
EDGECNTR_W, 8, width of each edge counter (>=1).
EDGE_MODE, 0, edges counted: 0 = both, 1 = rise only, 2 = fall only.
SATURATE, 1, 1 = counters saturate at all-ones; 0 = counters wrap.

Ports:
i_clk  in  1  clock.
i_rst_n  in  1  reset, asynchronous, active-low.
i_cg  in  1  clock-enable; 0 freezes all state.
i_debounceCycles  in  DEBOUNCE_W  required stable cycles; 0 is treated as 1.
i_bits  in  N_CH  raw asynchronous probe inputs.
i_snap  in  1  single-cycle snapshot request.
o_bits  out  N_CH  debounced levels.
o_rise  out  N_CH  one-cycle pulse on debounced rise.
o_fall  out  N_CH  one-cycle pulse on debounced fall.
o_count  out  N_CH*EDGECNTR_W  live edge counters; channel k at [k*EDGECNTR_W +: EDGECNTR_W].
o_snapCount  out  N_CH*EDGECNTR_W  counters captured at last snapshot.
o_snapOvf  out  N_CH  channel saturated/wrapped during the captured window.
o_snapValid  out  1  one-cycle pulse: snapshot outputs updated.

Behaviour:
- Reset (i_rst_n low, async): all outputs 0; all internal flops 0, including sync chain and debounce counts.
- Synchroniser: N_SYNC-flop chain per channel; s[k] is the last stage.
- Debounce, per channel:
  - cnt counts consecutive enabled cycles with s != o_bits.
  - cnt clears to 0 whenever s == o_bits.
  - Let D = max(i_debounceCycles, 1). On the edge where s != o_bits and cnt >= D-1: o_bits <= s and cnt <= 0.
  - Otherwise cnt increments, saturating at all-ones.
- Latency: an input change held stable is reflected on o_bits exactly N_SYNC + D cycles after the first sampling edge.
- Glitch rejection: a glitch shorter than D synchronised cycles never reaches o_bits and leaves cnt at 0 afterwards.
- Runtime change of i_debounceCycles: takes effect immediately. Lowering it below the current cnt causes the update on the next mismatched cycle.
- o_rise/o_fall: registered, asserted in the same cycle o_bits shows the new value, for exactly one cycle. They are never both high on one channel.
- Edge counting: the counted edge set is chosen by EDGE_MODE. Each counted edge increments o_count[k] one cycle after the pulse, so o_count is visible 1 cycle after o_rise/o_fall.
- Counter overflow:
  - SATURATE=1: the counter holds all-ones.
  - SATURATE=0: the counter wraps to 0.
  - In both modes a per-channel ovf flag sets sticky.
- Snapshot, when i_snap is high and i_cg is high:
  - Next edge: o_snapCount <= live counters including any increment due that same cycle; o_snapOvf <= ovf including any overflow due that same cycle.
  - Same edge: live counters clear to 0 and ovf clears.
  - o_snapValid pulses 1 cycle. No edge is lost or double-counted across the snapshot boundary.
- Back-to-back i_snap: each request produces its own capture; the second snapshot sees only edges counted in between.
- i_cg low:
  - All registers hold, including sync chain and counters.
  - o_rise, o_fall and o_snapValid are forced 0.
  - i_snap is ignored, not queued.
- Reset mid-debounce or mid-snapshot: state abandoned; post-reset o_bits is 0. A high input is then re-debounced and produces o_rise.

Decomposition:
- Package probe_cond_pkg:
  - EDGE_MODE encodings as localparams (EDGE_BOTH=0, EDGE_RISE=1, EDGE_FALL=2).
  - Function for the saturating/wrapping increment.
- Sub-module probe_cond_chan: one channel covering sync, debounce, edge pulses, counter and ovf, with snapshot-clear input.
  - The bank generates N_CH instances plus the shared snapshot registers and o_snapValid.

Test Plan:
- N_CH=8, N_SYNC=2, D=4; raise i_bits[3] and hold -> o_bits[3] and o_rise[3] rise exactly 6 cycles later; o_count[3]=1 one cycle after that.
- D=4; 3-cycle high glitch on i_bits[0] -> o_bits[0] stays 0, no pulse, count stays 0. Repeat with a 4-cycle high -> o_bits[0] rises.
- EDGE_MODE=1, SATURATE=1, EDGECNTR_W=4; 20 clean pulses on channel 1 -> o_count=15; snapshot -> o_snapCount=15, o_snapOvf[1]=1, live count 0.
- SATURATE=0, EDGECNTR_W=4; 17 rises then snapshot -> o_snapCount=1, o_snapOvf=1.
- Debounced edge on channel 2 whose count increment coincides with i_snap -> o_snapCount[2] includes it; live count 0 afterwards; 10 edges over repeated snapshots sum to 10 total.
- i_cg low for 100 cycles while i_bits toggles, i_snap pulses, and a prior mismatch is mid-count -> no o_bits change, no pulses, no o_snapValid, counters unchanged. Async reset asserted mid-count -> all outputs 0 immediately.
